// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: owns the PC, issues one request at a time to the
// instruction cache, buffers returned words in a small FIFO for the decoder and
// handles back-end redirects, including discarding a miss that was already in flight.
//
// state    | meaning
// ---------+------------------------------------------------------------------
// ST_RUN   | normal fetch; responses are pushed into the queue
// ST_DROP  | a redirect hit a miss in flight; the stale response is discarded
//          | and no fetch is issued until the cache reports ready again
module inst_fetch_queue #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  // cache request port
  output logic                  o_ce,
  output logic [ADDR_WIDTH-1:0] o_pc,
  // cache response port
  input  logic                  i_cache_ready,
  input  logic                  i_cache_valid,
  input  logic [ADDR_WIDTH-1:0] i_cache_addr,
  input  logic [DATA_WIDTH-1:0] i_cache_data,
  // redirect from the back end
  input  logic                  i_redirect,
  input  logic [ADDR_WIDTH-1:0] i_redirect_pc,
  // decoder port
  output logic                  o_valid,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_inst,
  input  logic                  i_dec_ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DROP = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] inst_mem [DEPTH];
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [CNT_W-1:0]      count;

  logic drop;
  logic not_full;
  logic push;
  logic pop;

  // Drop-state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Drop-state next-state logic; a redirect during a drop keeps the drop armed
  // because the old miss is still owed by the cache.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (i_redirect && !i_cache_ready) begin
          state_d = ST_DROP;
        end
      end
      ST_DROP: begin
        if (!i_redirect && i_cache_ready) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Request/response/decoder handshakes; o_ce deliberately ignores the response
  // and decoder-ready inputs so no combinational path loops through the cache.
  always_comb begin
    drop     = (state_q == ST_DROP);
    not_full = (count < FULL_CNT);
    o_ce     = !rst && i_cache_ready && !drop && !i_redirect && not_full;
    o_pc     = pc;
    push     = i_cache_valid && !drop && !i_redirect;
    o_valid  = !rst && (count != '0) && !i_redirect;
    o_addr   = addr_mem[head];
    o_inst   = inst_mem[head];
    pop      = o_valid && i_dec_ready;
  end

  // Program counter: redirect wins, otherwise advance on every accepted word
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (i_redirect) begin
      pc <= i_redirect_pc;
    end else if (push) begin
      pc <= pc + PC_STEP;
    end
  end

  // Queue storage write; entries need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      addr_mem[tail] <= i_cache_addr;
      inst_mem[tail] <= i_cache_data;
    end
  end

  // Queue pointers and occupancy; a redirect flushes everything
  always_ff @(posedge clk) begin
    if (rst || i_redirect) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= tail + PTR_W'(1);
      end
      if (pop) begin
        head <= head + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: hit streaming, backpressure with queue wrap,
// miss handling, redirect during a miss, simultaneous redirect/push/pop, reset mid-miss.
module tb_inst_fetch_queue;

  localparam logic [31:0] HIT_TAG = 32'h1000_0000;

  logic        clk;
  logic        rst;
  logic        o_ce;
  logic [31:0] o_pc;
  logic        i_cache_ready;
  logic        i_cache_valid;
  logic [31:0] i_cache_addr;
  logic [31:0] i_cache_data;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_valid;
  logic [31:0] o_addr;
  logic [31:0] o_inst;
  logic        i_dec_ready;

  logic        hit_mode;
  logic        man_valid;
  logic [31:0] man_addr;
  logic [31:0] man_data;

  int vectors;
  int miscompares;

  inst_fetch_queue #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .DEPTH     (4),
    .RESET_PC  (32'h0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .o_ce         (o_ce),
    .o_pc         (o_pc),
    .i_cache_ready(i_cache_ready),
    .i_cache_valid(i_cache_valid),
    .i_cache_addr (i_cache_addr),
    .i_cache_data (i_cache_data),
    .i_redirect   (i_redirect),
    .i_redirect_pc(i_redirect_pc),
    .o_valid      (o_valid),
    .o_addr       (o_addr),
    .o_inst       (o_inst),
    .i_dec_ready  (i_dec_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hit-mode cache answers the current request in the same cycle
  assign i_cache_valid = hit_mode ? o_ce : man_valid;
  assign i_cache_addr  = hit_mode ? o_pc : man_addr;
  assign i_cache_data  = hit_mode ? (o_pc + HIT_TAG) : man_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    rst           = 1'b1;
    hit_mode      = 1'b1;
    man_valid     = 1'b0;
    man_addr      = '0;
    man_data      = '0;
    i_cache_ready = 1'b1;
    i_redirect    = 1'b0;
    i_redirect_pc = '0;
    i_dec_ready   = 1'b1;

    // reset state
    repeat (3) cyc();
    mid();
    chk("rst_ce", {31'd0, o_ce}, 32'd0);
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_pc", o_pc, 32'h0);

    // hit stream from RESET_PC
    cyc(); rst = 1'b0;
    mid();
    chk("hit0_ce", {31'd0, o_ce}, 32'd1);
    chk("hit0_pc", o_pc, 32'h0);
    chk("hit0_valid", {31'd0, o_valid}, 32'd0);
    for (int i = 1; i <= 5; i++) begin
      cyc(); mid();
      chk("hit_valid", {31'd0, o_valid}, 32'd1);
      chk("hit_addr", o_addr, 32'(4 * (i - 1)));
      chk("hit_pc", o_pc, 32'(4 * i));
    end
    chk("hit_inst", o_inst, 32'h10 + HIT_TAG);

    // backpressure: flush to 0, fill the queue
    cyc(); i_redirect = 1'b1; i_redirect_pc = 32'h0; i_dec_ready = 1'b0;
    mid();
    chk("bp_redir_ce", {31'd0, o_ce}, 32'd0);
    chk("bp_redir_valid", {31'd0, o_valid}, 32'd0);
    cyc(); i_redirect = 1'b0;
    mid();
    chk("bp_first_ce", {31'd0, o_ce}, 32'd1);
    chk("bp_first_pc", o_pc, 32'h0);
    repeat (3) cyc();
    cyc(); mid();
    chk("bp_full_ce", {31'd0, o_ce}, 32'd0);
    chk("bp_full_pc", o_pc, 32'h10);
    chk("bp_full_addr", o_addr, 32'h0);
    // one-cycle decoder pulse
    cyc(); i_dec_ready = 1'b1;
    mid();
    chk("bp_pop_addr", o_addr, 32'h0);
    chk("bp_pop_ce", {31'd0, o_ce}, 32'd0);
    cyc(); i_dec_ready = 1'b0;
    mid();
    chk("bp_refill_ce", {31'd0, o_ce}, 32'd1);
    chk("bp_refill_pc", o_pc, 32'h10);
    chk("bp_refill_head", o_addr, 32'h4);
    cyc(); mid();
    chk("bp_refull_ce", {31'd0, o_ce}, 32'd0);
    chk("bp_refull_pc", o_pc, 32'h14);
    // drain with push+pop at count 3 across pointer wrap
    cyc(); i_dec_ready = 1'b1;
    mid();
    chk("wrap_head0", o_addr, 32'h4);
    chk("wrap_ce0", {31'd0, o_ce}, 32'd0);
    for (int j = 0; j < 4; j++) begin
      cyc(); mid();
      chk("wrap_addr", o_addr, 32'(8 + 4 * j));
      chk("wrap_ce", {31'd0, o_ce}, 32'd1);
    end
    chk("wrap_inst", o_inst, 32'h14 + HIT_TAG);

    // miss at 0x40, word returns 10 cycles after the request
    cyc(); hit_mode = 1'b0; man_valid = 1'b0; i_redirect = 1'b1; i_redirect_pc = 32'h40;
    mid();
    chk("miss_redir_ce", {31'd0, o_ce}, 32'd0);
    cyc(); i_redirect = 1'b0;
    mid();
    chk("miss_req_ce", {31'd0, o_ce}, 32'd1);
    chk("miss_req_pc", o_pc, 32'h40);
    for (int k = 0; k < 9; k++) begin
      cyc(); i_cache_ready = 1'b0;
      mid();
      chk("miss_wait_ce", {31'd0, o_ce}, 32'd0);
    end
    cyc(); man_valid = 1'b1; man_addr = 32'h40; man_data = 32'hDEAD_0040;
    mid();
    chk("miss_resp_ce", {31'd0, o_ce}, 32'd0);
    chk("miss_resp_valid", {31'd0, o_valid}, 32'd0);
    cyc(); man_valid = 1'b0; i_cache_ready = 1'b1; hit_mode = 1'b1;
    mid();
    chk("miss_out_valid", {31'd0, o_valid}, 32'd1);
    chk("miss_out_addr", o_addr, 32'h40);
    chk("miss_out_inst", o_inst, 32'hDEAD_0040);
    chk("miss_next_pc", o_pc, 32'h44);
    chk("miss_resume_ce", {31'd0, o_ce}, 32'd1);

    // redirect to 0x200 while the 0x80 miss is in flight
    cyc(); hit_mode = 1'b0; man_valid = 1'b0; i_redirect = 1'b1; i_redirect_pc = 32'h80;
    mid();
    chk("rdm_flush_valid", {31'd0, o_valid}, 32'd0);
    cyc(); i_redirect = 1'b0;
    mid();
    chk("rdm_req_ce", {31'd0, o_ce}, 32'd1);
    chk("rdm_req_pc", o_pc, 32'h80);
    cyc(); i_cache_ready = 1'b0; i_redirect = 1'b1; i_redirect_pc = 32'h200;
    mid();
    chk("rdm_redir_ce", {31'd0, o_ce}, 32'd0);
    chk("rdm_redir_valid", {31'd0, o_valid}, 32'd0);
    cyc(); i_redirect = 1'b0;
    mid();
    chk("rdm_pc", o_pc, 32'h200);
    chk("rdm_wait_ce", {31'd0, o_ce}, 32'd0);
    cyc(); man_valid = 1'b1; man_addr = 32'h80; man_data = 32'hBAD0_0080;
    mid();
    chk("rdm_stale_valid", {31'd0, o_valid}, 32'd0);
    cyc(); man_valid = 1'b0; i_cache_ready = 1'b1;
    mid();
    chk("rdm_clear_ce", {31'd0, o_ce}, 32'd0);
    chk("rdm_clear_valid", {31'd0, o_valid}, 32'd0);
    chk("rdm_clear_pc", o_pc, 32'h200);
    cyc(); hit_mode = 1'b1;
    mid();
    chk("rdm_fetch_ce", {31'd0, o_ce}, 32'd1);
    chk("rdm_fetch_pc", o_pc, 32'h200);
    chk("rdm_fetch_valid", {31'd0, o_valid}, 32'd0);
    cyc(); mid();
    chk("rdm_first_valid", {31'd0, o_valid}, 32'd1);
    chk("rdm_first_addr", o_addr, 32'h200);
    chk("rdm_first_inst", o_inst, 32'h200 + HIT_TAG);

    // redirect + push + pop together at count 2
    cyc(); i_redirect = 1'b1; i_redirect_pc = 32'h300; i_dec_ready = 1'b0;
    mid();
    cyc(); i_redirect = 1'b0;
    mid();
    chk("sim_fill_pc", o_pc, 32'h300);
    chk("sim_fill_ce", {31'd0, o_ce}, 32'd1);
    cyc(); mid();
    chk("sim_head_addr", o_addr, 32'h300);
    cyc(); hit_mode = 1'b0; man_valid = 1'b1; man_addr = 32'h308; man_data = 32'h1000_0308;
    i_redirect = 1'b1; i_redirect_pc = 32'h400; i_dec_ready = 1'b1;
    mid();
    chk("sim_redir_valid", {31'd0, o_valid}, 32'd0);
    chk("sim_redir_ce", {31'd0, o_ce}, 32'd0);
    cyc(); i_redirect = 1'b0; man_valid = 1'b0; hit_mode = 1'b1;
    mid();
    chk("sim_empty_valid", {31'd0, o_valid}, 32'd0);
    chk("sim_new_pc", o_pc, 32'h400);
    chk("sim_new_ce", {31'd0, o_ce}, 32'd1);
    cyc(); mid();
    chk("sim_first_valid", {31'd0, o_valid}, 32'd1);
    chk("sim_first_addr", o_addr, 32'h400);

    // reset while a miss is outstanding
    cyc(); hit_mode = 1'b0; man_valid = 1'b0; rst = 1'b1; i_cache_ready = 1'b0;
    mid();
    chk("rmm_rst_ce", {31'd0, o_ce}, 32'd0);
    cyc(); rst = 1'b0;
    mid();
    chk("rmm_pc", o_pc, 32'h0);
    chk("rmm_ce", {31'd0, o_ce}, 32'd0);
    chk("rmm_valid", {31'd0, o_valid}, 32'd0);
    cyc(); i_cache_ready = 1'b1;
    mid();
    chk("rmm_resume_ce", {31'd0, o_ce}, 32'd1);
    chk("rmm_resume_pc", o_pc, 32'h0);

    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
